// File: rtl/add_arb_pkg.sv
// ---------------------------------------------------------------------------
// add_arb_pkg -- shared definitions for the round-robin adder arbiter.
//   state_t        : controller states (IDLE, EXEC, RESP)
//   ADD_ARB_NREQ   : default number of requesters
//   ADD_ARB_WIDTH  : default operand / sum width
// ---------------------------------------------------------------------------
package add_arb_pkg;

  localparam int ADD_ARB_NREQ  = 4;
  localparam int ADD_ARB_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder32bit.sv
// ---------------------------------------------------------------------------
// adder32bit -- plain ripple/inferred adder with carry-in and carry-out.
//   a, b  : operands (WIDTH bits)
//   cin   : carry-in
//   s     : (a + b + cin) mod 2^WIDTH
//   cout  : bit WIDTH of the full sum
// ---------------------------------------------------------------------------
module adder32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/add_arbiter.sv
// ---------------------------------------------------------------------------
// add_arbiter -- round-robin arbiter in front of a single shared adder.
// One operation is in flight at a time: IDLE grants one requester, EXEC
// registers the sum, RESP holds the result until the consumer takes it.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid[i]    : requester i has an operation pending (held until taken)
//   req_a, req_b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin[i]      : per-requester carry-in
//   req_ready[i]    : one-hot accept pulse to the winning requester
//   rsp_valid       : result available (RESP state)
//   rsp_ready       : consumer accepts result
//   rsp_sum, rsp_cout, rsp_id : registered result, carry-out, owner index
//
// Configuration macro ADD_ARB_CARRY_EN: when defined, req_cin feeds the
// adder carry-in and rsp_cout carries the adder carry-out; otherwise the
// carry-in is 0, req_cin is ignored and rsp_cout is tied 0.
// ---------------------------------------------------------------------------
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int NREQ  = ADD_ARB_NREQ,
  parameter int WIDTH = ADD_ARB_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [$clog2(NREQ)-1:0]  rsp_id
);

  localparam int ID_W = $clog2(NREQ);
  localparam int PW   = ID_W + 1;  // room for rr_ptr + offset before wrapping

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [PW-1:0]    cand;
  logic             take;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [WIDTH-1:0] op_a, op_b;
  logic [ID_W-1:0]  op_id;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first set req_valid bit at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + PW'(k);
      if (cand >= PW'(NREQ)) cand = cand - PW'(NREQ);
      if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  assign take       = (state == IDLE) && grant_any;
  assign rr_ptr_nxt = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Gated with rst_n so no grant is ever visible while reset is held.
  assign req_ready = (take && rst_n) ? (NREQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand holding registers are reset too, so nothing undefined can reach rsp_* after bring-up.
      rr_ptr  <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_id   <= '0;
      rsp_sum <= '0;
      rsp_id  <= '0;
    end else begin
      if (take) begin
        op_a   <= a_arr[grant_idx];
        op_b   <= b_arr[grant_idx];
        op_id  <= grant_idx;
        rr_ptr <= rr_ptr_nxt;
      end
      if (state == EXEC) begin
        rsp_sum <= add_s;
        rsp_id  <= op_id;
      end
    end
  end

`ifdef ADD_ARB_CARRY_EN
  logic op_cin;
  logic rsp_cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cin     <= 1'b0;
      rsp_cout_q <= 1'b0;
    end else begin
      if (take)          op_cin     <= req_cin[grant_idx];
      if (state == EXEC) rsp_cout_q <= add_cout;
    end
  end

  assign add_cin  = op_cin;
  assign rsp_cout = rsp_cout_q;
`else
  logic unused_carry;

  assign add_cin      = 1'b0;
  assign rsp_cout     = 1'b0;
  assign unused_carry = ^{req_cin, add_cout};
`endif

  adder32bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

endmodule
